// File: rtl/forward_unit_ms.sv
// forward_unit_ms
// Forwarding and hazard unit for the pipelined datapath. Resolves NREAD
// decode-stage source registers against NSTAGE downstream write stages
// (stage 0 = youngest), raises a load-use stall when the selected value is
// still pending, keeps a per-port hold buffer of values retiring from the
// oldest stage while decode is frozen, and counts stall cycles (saturating).
//
// Ports:
//   CLK          system clock
//   nRST         asynchronous active-low reset
//   rsel         NREAD x 5-bit source register, port p at [5p+4:5p]
//   st_wsel      NSTAGE x 5-bit destination register per stage
//   st_wen       per-stage register-write flag
//   st_pend      per-stage "write data not available yet"
//   st_wdata     NSTAGE x 32-bit write data
//   dec_advance  decode latch advances at this edge
//   flush        decode flush
//   fwd_sel      per-port source: 0 regfile, k+1 stage k, NSTAGE+1 hold
//   fwd_data     per-port forwarded data (0 when fwd_sel=0)
//   hazard_stall decode must stall
//   stall_cnt    saturating count of stalled cycles
//
// Handshake: purely level-based. Outputs are valid in the same cycle as the
// inputs that produce them; hold state and the counter update on CLK edges.
module forward_unit_ms #(
    parameter int NREAD  = 2,
    parameter int NSTAGE = 2,
    parameter int CNTW   = 16,
    localparam int SELW  = $clog2(NSTAGE + 2)
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic [NREAD*5-1:0]      rsel,
    input  logic [NSTAGE*5-1:0]     st_wsel,
    input  logic [NSTAGE-1:0]       st_wen,
    input  logic [NSTAGE-1:0]       st_pend,
    input  logic [NSTAGE*32-1:0]    st_wdata,
    input  logic                    dec_advance,
    input  logic                    flush,
    output logic [NREAD*SELW-1:0]   fwd_sel,
    output logic [NREAD*32-1:0]     fwd_data,
    output logic                    hazard_stall,
    output logic [CNTW-1:0]         stall_cnt
);

    logic [NSTAGE-1:0] matchV   [NREAD];
    logic              holdV    [NREAD];
    logic [4:0]        holdTag  [NREAD];
    logic [31:0]       holdData [NREAD];
    logic [SELW-1:0]   selC     [NREAD];
    logic [31:0]       dataC    [NREAD];
    logic              pendC    [NREAD];
    logic              stallC;

    // Match(p,k): stage k writes the register port p reads; r0 never matches.
    always_comb begin
        for (int p = 0; p < NREAD; p++) begin
            matchV[p] = '0;
            for (int k = 0; k < NSTAGE; k++) begin
                matchV[p][k] = st_wen[k]
                             && (st_wsel[5*k +: 5] == rsel[5*p +: 5])
                             && (rsel[5*p +: 5] != 5'd0);
            end
        end
    end

    // Source selection. The hold entry is the weakest candidate; stages are
    // then scanned oldest to youngest so the youngest match is the last
    // writer. The stall comes only from the finally selected stage, so a
    // pending older stage shadowed by a younger match is ignored.
    always_comb begin
        stallC = 1'b0;
        for (int p = 0; p < NREAD; p++) begin
            selC[p]  = '0;
            dataC[p] = '0;
            pendC[p] = 1'b0;
            if (holdV[p] && (holdTag[p] == rsel[5*p +: 5]) && (rsel[5*p +: 5] != 5'd0)) begin
                selC[p]  = SELW'(NSTAGE + 1);
                dataC[p] = holdData[p];
            end
            for (int k = NSTAGE - 1; k >= 0; k--) begin
                if (matchV[p][k]) begin
                    selC[p]  = SELW'(k + 1);
                    dataC[p] = st_wdata[32*k +: 32];
                    pendC[p] = st_pend[k];
                end
            end
            stallC = stallC | pendC[p];
        end
    end

    always_comb begin
        fwd_sel  = '0;
        fwd_data = '0;
        for (int p = 0; p < NREAD; p++) begin
            fwd_sel[SELW*p +: SELW] = selC[p];
            fwd_data[32*p +: 32]    = dataC[p];
        end
    end

    assign hazard_stall = stallC;

    // Hold buffer: a frozen decode keeps seeing values that retire from the
    // oldest stage, independent of regfile write/read ordering. Any advance
    // or flush invalidates it, since the consumer instruction has changed.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int p = 0; p < NREAD; p++) begin
                holdV[p]    <= 1'b0;
                holdTag[p]  <= 5'd0;
                holdData[p] <= 32'd0;
            end
        end else if (flush || dec_advance) begin
            for (int p = 0; p < NREAD; p++) begin
                holdV[p] <= 1'b0;
            end
        end else begin
            for (int p = 0; p < NREAD; p++) begin
                if (matchV[p][NSTAGE-1] && !st_pend[NSTAGE-1]) begin
                    holdV[p]    <= 1'b1;
                    holdTag[p]  <= rsel[5*p +: 5];
                    holdData[p] <= st_wdata[32*(NSTAGE-1) +: 32];
                end
            end
        end
    end

    // Saturating stall counter; flush does not touch it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
        end else if (stallC && (stall_cnt != {CNTW{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_forward_unit_ms.sv
module tb_forward_unit_ms;

  localparam int NREAD  = 2;
  localparam int NSTAGE = 2;
  localparam int SELW   = 2;
  localparam int W      = NREAD*SELW + NREAD*32 + 1 + 16 + 4;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  logic [NREAD*5-1:0]    rsel;
  logic [NSTAGE*5-1:0]   st_wsel;
  logic [NSTAGE-1:0]     st_wen;
  logic [NSTAGE-1:0]     st_pend;
  logic [NSTAGE*32-1:0]  st_wdata;
  logic                  dec_advance;
  logic                  flush;

  logic [NREAD*SELW-1:0] fwd_sel;
  logic [NREAD*32-1:0]   fwd_data;
  logic                  hazard_stall;
  logic [15:0]           stall_cnt;

  logic [NREAD*SELW-1:0] s_fwd_sel;
  logic [NREAD*32-1:0]   s_fwd_data;
  logic                  s_hazard_stall;
  logic [3:0]            s_stall_cnt;

  forward_unit_ms #(.NREAD(NREAD), .NSTAGE(NSTAGE), .CNTW(16)) dut (
    .CLK(CLK), .nRST(nRST), .rsel(rsel), .st_wsel(st_wsel), .st_wen(st_wen),
    .st_pend(st_pend), .st_wdata(st_wdata), .dec_advance(dec_advance), .flush(flush),
    .fwd_sel(fwd_sel), .fwd_data(fwd_data), .hazard_stall(hazard_stall), .stall_cnt(stall_cnt)
  );

  // narrow-counter instance for saturation
  forward_unit_ms #(.NREAD(NREAD), .NSTAGE(NSTAGE), .CNTW(4)) dut_sat (
    .CLK(CLK), .nRST(nRST), .rsel(rsel), .st_wsel(st_wsel), .st_wen(st_wen),
    .st_pend(st_pend), .st_wdata(st_wdata), .dec_advance(dec_advance), .flush(flush),
    .fwd_sel(s_fwd_sel), .fwd_data(s_fwd_data), .hazard_stall(s_hazard_stall), .stall_cnt(s_stall_cnt)
  );

  // ---------------- reference model ----------------
  logic        m_hv [NREAD];
  logic [4:0]  m_ht [NREAD];
  logic [31:0] m_hd [NREAD];
  int          m_cnt;
  int          m_cnt4;

  function automatic logic m_match(int p, int k);
    return st_wen[k] && (st_wsel[5*k +: 5] == rsel[5*p +: 5]) && (rsel[5*p +: 5] != 5'd0);
  endfunction

  function automatic logic m_stall();
    logic s = 1'b0;
    for (int p = 0; p < NREAD; p++) begin
      int hits[$];
      for (int k = 0; k < NSTAGE; k++) if (m_match(p, k)) hits.push_back(k);
      if (hits.size() > 0) s = s | st_pend[hits[0]];
    end
    return s;
  endfunction

  function automatic logic [W-1:0] m_eval();
    logic [NREAD*SELW-1:0] s = '0;
    logic [NREAD*32-1:0]   d = '0;
    logic [15:0]           c16;
    logic [3:0]            c4;
    for (int p = 0; p < NREAD; p++) begin
      int hits[$];
      for (int k = 0; k < NSTAGE; k++) if (m_match(p, k)) hits.push_back(k);
      if (hits.size() > 0) begin
        s[p*SELW +: SELW] = SELW'(hits[0] + 1);
        d[p*32 +: 32]     = st_wdata[32*hits[0] +: 32];
      end else if (m_hv[p] && m_ht[p] == rsel[5*p +: 5] && rsel[5*p +: 5] != 5'd0) begin
        s[p*SELW +: SELW] = SELW'(NSTAGE + 1);
        d[p*32 +: 32]     = m_hd[p];
      end
    end
    c16 = m_cnt[15:0];
    c4  = m_cnt4[3:0];
    return {s, d, m_stall(), c16, c4};
  endfunction

  task automatic m_edge();
    if (m_stall()) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    for (int p = 0; p < NREAD; p++) begin
      if (flush || dec_advance) m_hv[p] = 1'b0;
      else if (m_match(p, NSTAGE-1) && !st_pend[NSTAGE-1]) begin
        m_hv[p] = 1'b1;
        m_ht[p] = rsel[5*p +: 5];
        m_hd[p] = st_wdata[32*(NSTAGE-1) +: 32];
      end
    end
  endtask

  task automatic m_reset();
    for (int p = 0; p < NREAD; p++) begin
      m_hv[p] = 1'b0; m_ht[p] = 5'd0; m_hd[p] = 32'd0;
    end
    m_cnt = 0; m_cnt4 = 0;
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int n_cmp = 0;
  int n_err = 0;

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {fwd_sel, fwd_data, hazard_stall, stall_cnt, s_stall_cnt};
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL %s: got sel=%h data=%h stall=%b cnt=%0d cnt4=%0d, expected sel=%h data=%h stall=%b cnt=%0d cnt4=%0d",
                 nm, a[W-1 -: 4], a[W-5 -: 64], a[20], a[19:4], a[3:0],
                 e[W-1 -: 4], e[W-5 -: 64], e[20], e[19:4], e[3:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called 1 time unit after a posedge with inputs already applied.
  task automatic cycle(input string nm);
    exp_q.push_back(m_eval());
    name_q.push_back(nm);
    @(posedge CLK);
    if (nRST) m_edge();
    #1;
  endtask

  task automatic set_stage(input int k, input logic wen, input logic [4:0] ws,
                           input logic pend, input logic [31:0] d);
    st_wen[k]          = wen;
    st_wsel[5*k +: 5]  = ws;
    st_pend[k]         = pend;
    st_wdata[32*k +: 32] = d;
  endtask

  task automatic clear_inputs();
    rsel = '0; st_wsel = '0; st_wen = '0; st_pend = '0; st_wdata = '0;
    dec_advance = 1'b0; flush = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_inputs();
    nRST = 1'b0;
    m_reset();
    @(posedge CLK); #1;

    // reset with arbitrary inputs (no writes), then release
    rsel = 10'($urandom); st_pend = 2'b11; st_wdata = {$urandom, $urandom};
    cycle("reset_hold");
    nRST = 1'b1;
    cycle("reset_release");

    // priority: youngest stage wins
    clear_inputs();
    rsel[4:0] = 5'd5;
    set_stage(0, 1'b1, 5'd5, 1'b0, 32'hAAAA);
    set_stage(1, 1'b1, 5'd5, 1'b0, 32'hBBBB);
    cycle("prio_young");
    st_wen[0] = 1'b0;
    cycle("prio_old");

    // load-use stall then release
    clear_inputs();
    rsel[9:5] = 5'd8;
    set_stage(0, 1'b1, 5'd8, 1'b1, 32'hDEAD);
    for (int i = 0; i < 3; i++) cycle("load_use");
    set_stage(0, 1'b1, 5'd8, 1'b0, 32'h1234);
    cycle("load_ready");

    // hold capture, then advance clears it
    clear_inputs();
    rsel[4:0] = 5'd3;
    set_stage(1, 1'b1, 5'd3, 1'b0, 32'hCAFE);
    cycle("cap_edge");
    st_wen[1] = 1'b0;
    cycle("hold_fwd");
    dec_advance = 1'b1;
    cycle("hold_adv_edge");
    dec_advance = 1'b0;
    cycle("hold_cleared");

    // register zero never forwards or stalls
    clear_inputs();
    set_stage(0, 1'b1, 5'd0, 1'b1, 32'h5555);
    cycle("reg_zero");

    // flush beats a simultaneous capture
    clear_inputs();
    rsel[4:0] = 5'd4;
    set_stage(1, 1'b1, 5'd4, 1'b0, 32'h4444);
    cycle("fill_hold");
    flush = 1'b1;
    cycle("flush_edge");
    flush = 1'b0;
    st_wen[1] = 1'b0;
    cycle("flush_clr");

    // saturation of the narrow counter
    clear_inputs();
    rsel[4:0] = 5'd9;
    set_stage(0, 1'b1, 5'd9, 1'b1, 32'h9);
    for (int i = 0; i < 20; i++) cycle("sat");

    // reset mid-stall: counter restarts from zero
    nRST = 1'b0;
    m_reset();
    cycle("reset_mid");
    nRST = 1'b1;
    cycle("reset_restart");
    cycle("restart_count");

    // randomized traffic on a small register range to force collisions
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < NREAD; p++) rsel[5*p +: 5] = 5'($urandom_range(0, 7));
      for (int k = 0; k < NSTAGE; k++)
        set_stage(k, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) == 0), $urandom);
      dec_advance = ($urandom_range(0, 2) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      cycle("random");
    end

    clear_inputs();
    repeat (3) @(negedge CLK);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
